alu_arbiter: RTL and testbench

Shares one 16-bit ALU between two requesters using round-robin arbitration. Each requester submits operands and an opcode with a valid/ready handshake. The block registers the operands, evaluates them on an internal `alu` instance and returns a registered result plus zero flag through a per-requester valid/ready response channel. It sits between the decode/issue logic of two clients (e.g. main datapath and address-generation path) and the single shared ALU.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu.sv | 29 ++
 rtl/alu_arbiter.sv | 94 +++++++++
 tb/tb_alu_arbiter.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the two-client ALU arbiter.
// Opcode encodings, FSM state type and default widths.
package alu_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int OPW_DEF   = 3;

  localparam logic [OPW_DEF-1:0] ALU_ADD = 3'b000;
  localparam logic [OPW_DEF-1:0] ALU_SUB = 3'b001;
  localparam logic [OPW_DEF-1:0] ALU_AND = 3'b010;
  localparam logic [OPW_DEF-1:0] ALU_OR  = 3'b011;
  localparam logic [OPW_DEF-1:0] ALU_SLT = 3'b100;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU shared by both arbiter clients.
// Unused opcodes fall back to add.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int OPW   = OPW_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OPW-1:0]   alu_control,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  always_comb begin
    result = a + b;
    case (alu_control)
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, (a < b)};
      default: result = a + b;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two requesters.
// IDLE grants and captures, EXEC evaluates, RESP holds the result.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int OPW   = OPW_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0][WIDTH-1:0] req_a,
  input  logic [1:0][WIDTH-1:0] req_b,
  input  logic [1:0][OPW-1:0]   req_op,
  output logic [1:0]            rsp_valid,
  input  logic [1:0]            rsp_ready,
  output logic [WIDTH-1:0]      rsp_result,
  output logic                  rsp_zero,
  output logic                  busy
);

  arb_state_t       state;
  logic             prio;
  logic             gnt;
  logic             sel;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [OPW-1:0]   op_c;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;

  // prio only breaks ties; a lone requester always wins
  always_comb begin
    sel = req_valid[1];
    if (req_valid == 2'b11) sel = prio;
  end

  assign req_ready = (rst_n && state == IDLE && |req_valid)
                   ? (sel ? 2'b10 : 2'b01) : 2'b00;
  assign busy = (state != IDLE);

  alu #(
    .WIDTH(WIDTH),
    .OPW  (OPW)
  ) u_alu (
    .a          (op_a),
    .b          (op_b),
    .alu_control(op_c),
    .result     (alu_result),
    .zero       (alu_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      prio       <= 1'b0;
      gnt        <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      op_c       <= '0;
      rsp_valid  <= 2'b00;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            gnt   <= sel;
            op_a  <= req_a[sel];
            op_b  <= req_b[sel];
            op_c  <= req_op[sel];
            prio  <= ~sel;
            state <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
          rsp_valid  <= gnt ? 2'b10 : 2'b01;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready[gnt]) begin
            rsp_valid <= 2'b00;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: accepted requests push a
// model result, observed response handshakes pop and compare.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       req_valid = '0;
  logic [1:0]       req_ready;
  logic [1:0][15:0] req_a = '0;
  logic [1:0][15:0] req_b = '0;
  logic [1:0][2:0]  req_op = '0;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready = '0;
  logic [15:0]      rsp_result;
  logic             rsp_zero;
  logic             busy;

  alu_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_result(rsp_result),
    .rsp_zero  (rsp_zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        port;
    logic [15:0] res;
    logic        zero;
  } exp_t;

  exp_t sbq[$];
  int   grant_log[$];
  int   grant_cyc[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  exp_t mon_e;

  always @(posedge clk) cyc++;

  function automatic logic [15:0] model(logic [15:0] a, logic [15:0] b,
                                        logic [2:0] op);
    case (op)
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return (a < b) ? 16'd1 : 16'd0;
      default: return a + b;
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst_n && req_valid[i] && req_ready[i]) begin
        mon_e.port = i[0];
        mon_e.res  = model(req_a[i], req_b[i], req_op[i]);
        mon_e.zero = (mon_e.res == 16'h0);
        sbq.push_back(mon_e);
        grant_log.push_back(i);
        grant_cyc.push_back(cyc);
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (rsp_valid[i] && rsp_ready[i]) begin
        tests++;
        if (sbq.size() == 0) begin
          fails++;
          $display("FAIL rsp_unexpected port=%0d got=%h required=none",
                   i, rsp_result);
        end else begin
          mon_e = sbq.pop_front();
          if (mon_e.port !== i[0] || rsp_result !== mon_e.res ||
              rsp_zero !== mon_e.zero) begin
            fails++;
            $display("FAIL rsp_data port=%0d/%0d result=%h/%h zero=%b/%b",
                     i, mon_e.port, rsp_result, mon_e.res,
                     rsp_zero, mon_e.zero);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    sbq.delete();
    grant_log.delete();
    grant_cyc.delete();
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!busy && rsp_valid == 2'b00) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout busy=%b rsp_valid=%b required=0/00",
               busy, rsp_valid);
    end
    tick();
  endtask

  task automatic issue(int p, logic [15:0] a, logic [15:0] b,
                       logic [2:0] op);
    bit got = 0;
    req_a[p] = a;
    req_b[p] = b;
    req_op[p] = op;
    req_valid[p] = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (req_ready[p]) begin
        got = 1;
        break;
      end
    end
    tick();
    req_valid[p] = 1'b0;
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL issue_timeout port=%0d ready=0 required=1", p);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 2'b11;
    #1;
    tests++;
    if (req_ready !== 2'b00 || rsp_valid !== 2'b00 ||
        rsp_result !== 16'h0 || rsp_zero !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_state rdy=%b vld=%b res=%h z=%b busy=%b required=0",
               req_ready, rsp_valid, rsp_result, rsp_zero, busy);
    end
    repeat (2) tick();
    req_valid = '0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    rsp_ready = 2'b11;
    req_a[0] = 16'd5;
    req_b[0] = 16'd3;
    req_op[0] = ALU_SUB;
    req_valid[0] = 1'b1;
    @(negedge clk);
    tests++;
    if (req_ready !== 2'b01) begin
      fails++;
      $display("FAIL single_ready got=%b required=01", req_ready);
    end
    tick();
    req_valid = '0;
    @(negedge clk);
    tests++;
    if (rsp_valid !== 2'b00 || busy !== 1'b1) begin
      fails++;
      $display("FAIL single_exec vld=%b busy=%b required=00/1",
               rsp_valid, busy);
    end
    @(negedge clk);
    tests++;
    if (rsp_valid !== 2'b01 || rsp_result !== 16'h0002 || rsp_zero !== 1'b0) begin
      fails++;
      $display("FAIL single_resp vld=%b res=%h z=%b required=01/0002/0",
               rsp_valid, rsp_result, rsp_zero);
    end
    wait_idle();
  endtask

  task automatic test_both();
    logic [1:0] r;
    do_reset();
    rsp_ready = 2'b11;
    req_a[0] = 16'hFFFF;
    req_b[0] = 16'h0001;
    req_op[0] = ALU_ADD;
    req_a[1] = 16'h0001;
    req_b[1] = 16'h0002;
    req_op[1] = ALU_SLT;
    req_valid = 2'b11;
    for (int k = 0; k < 30 && req_valid != 2'b00; k++) begin
      @(negedge clk);
      r = req_ready;
      tick();
      req_valid = req_valid & ~r;
    end
    req_valid = '0;
    wait_idle();
    tests++;
    if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 1) begin
      fails++;
      $display("FAIL both_order count=%0d first=%0d required=2/0",
               grant_log.size(), grant_log.size() > 0 ? grant_log[0] : -1);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] r;
    do_reset();
    rsp_ready = 2'b11;
    for (int p = 0; p < 2; p++) begin
      req_a[p] = 16'($urandom);
      req_b[p] = 16'($urandom);
      req_op[p] = 3'($urandom_range(0, 7));
    end
    req_valid = 2'b11;
    for (int k = 0; k < 60 && grant_log.size() < 6; k++) begin
      @(negedge clk);
      r = req_ready;
      tick();
      for (int p = 0; p < 2; p++) begin
        if (r[p]) begin
          req_a[p] = 16'($urandom);
          req_b[p] = 16'($urandom);
          req_op[p] = 3'($urandom_range(0, 7));
        end
      end
    end
    req_valid = '0;
    wait_idle();
    tests++;
    if (grant_log.size() != 6) begin
      fails++;
      $display("FAIL rr_count got=%0d required=6", grant_log.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        tests++;
        if (grant_log[k] != k % 2) begin
          fails++;
          $display("FAIL rr_order idx=%0d got=%0d required=%0d",
                   k, grant_log[k], k % 2);
        end
      end
      for (int k = 1; k < 6; k++) begin
        tests++;
        if (grant_cyc[k] - grant_cyc[k-1] != 3) begin
          fails++;
          $display("FAIL rr_spacing idx=%0d got=%0d required=3",
                   k, grant_cyc[k] - grant_cyc[k-1]);
        end
      end
    end
  endtask

  task automatic test_hold();
    logic [15:0] held;
    rsp_ready = 2'b01;
    issue(1, 16'h00FF, 16'h0F00, ALU_OR);
    @(negedge clk);
    @(negedge clk);
    held = rsp_result;
    tests++;
    if (rsp_valid !== 2'b10 || held !== 16'h0FFF) begin
      fails++;
      $display("FAIL hold_first vld=%b res=%h required=10/0fff",
               rsp_valid, held);
    end
    tick();
    req_valid[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      tests++;
      if (rsp_valid !== 2'b10 || rsp_result !== held || rsp_zero !== 1'b0 ||
          req_ready !== 2'b00 || busy !== 1'b1) begin
        fails++;
        $display("FAIL hold_stable cyc=%0d vld=%b res=%h rdy=%b busy=%b required=10/%h/00/1",
                 k, rsp_valid, rsp_result, req_ready, busy, held);
      end
    end
    tick();
    req_valid = '0;
    rsp_ready = 2'b11;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || rsp_valid !== 2'b00) begin
      fails++;
      $display("FAIL hold_release busy=%b vld=%b required=0/00",
               busy, rsp_valid);
    end
    tick();
  endtask

  task automatic test_reset_exec();
    rsp_ready = 2'b11;
    req_a[0] = 16'd7;
    req_b[0] = 16'd8;
    req_op[0] = ALU_ADD;
    req_a[1] = 16'd9;
    req_b[1] = 16'd1;
    req_op[1] = ALU_SUB;
    req_valid = 2'b11;
    @(negedge clk);
    tests++;
    if (req_ready !== 2'b01) begin
      fails++;
      $display("FAIL rst_pre_grant got=%b required=01", req_ready);
    end
    tick();
    req_valid = '0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || rsp_result !== 16'h0 ||
        rsp_zero !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rst_exec rdy=%b vld=%b res=%h z=%b busy=%b required=0",
               req_ready, rsp_valid, rsp_result, rsp_zero, busy);
    end
    sbq.delete();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      tests++;
      if (rsp_valid !== 2'b00) begin
        fails++;
        $display("FAIL rst_no_rsp cyc=%0d vld=%b required=00", k, rsp_valid);
      end
    end
    tick();
    req_valid = 2'b11;
    @(negedge clk);
    tests++;
    if (req_ready !== 2'b01) begin
      fails++;
      $display("FAIL rst_prio got=%b required=01", req_ready);
    end
    tick();
    req_valid = '0;
    wait_idle();
  endtask

  task automatic test_ops();
    rsp_ready = 2'b11;
    issue(0, 16'h1234, 16'h0001, 3'b111);
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (rsp_valid !== 2'b01 || rsp_result !== 16'h1235) begin
      fails++;
      $display("FAIL op_default vld=%b res=%h required=01/1235",
               rsp_valid, rsp_result);
    end
    wait_idle();
    issue(1, 16'hF0F0, 16'h0F0F, ALU_AND);
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (rsp_valid !== 2'b10 || rsp_result !== 16'h0000 || rsp_zero !== 1'b1) begin
      fails++;
      $display("FAIL op_and vld=%b res=%h z=%b required=10/0000/1",
               rsp_valid, rsp_result, rsp_zero);
    end
    wait_idle();
    issue(0, 16'd3, 16'd5, ALU_SLT);
    wait_idle();
    issue(1, 16'd5, 16'd3, ALU_SLT);
    wait_idle();
    issue(0, 16'd3, 16'd5, ALU_SUB);
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_both();
    test_back_to_back();
    test_hold();
    test_reset_exec();
    test_ops();
    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL sb_leftover got=%0d required=0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
